// File: rtl/cpu_div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_div_pkg
// Description : Shared constants and types for the divider arbiter slice.
//               Holds the arbiter FSM state encoding, the requester-id width
//               and the all-ones quotient returned for a divide by zero.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_div_pkg;

  // Requester id width: two requesters, one id bit.
  localparam int ID_W = 1;

  // Widest operand the arbiter supports; DIV_ZERO_QUOT is sliced down to the
  // instance's DATA_W where it is used.
  localparam int MAX_DATA_W = 64;
  localparam logic [MAX_DATA_W-1:0] DIV_ZERO_QUOT = {MAX_DATA_W{1'b1}};

  // Arbiter state encoding.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_BUSY  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_START = ST_START,
    S_BUSY  = ST_BUSY,
    S_RESP  = ST_RESP
  } state_t;

endpackage : cpu_div_pkg
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin grant, purely combinational. The priority
//               pointer is owned by the caller.
// Ports       : valid0/valid1 - requests
//               ptr           - requester favoured when both request
//               gnt0/gnt1     - one-hot grant (both 0 when nobody requests)
//               gnt_id        - index of the granted requester
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
  input  logic valid0,
  input  logic valid1,
  input  logic ptr,
  output logic gnt0,
  output logic gnt1,
  output logic gnt_id
);

  assign gnt0   = valid0 & (~valid1 | ~ptr);
  assign gnt1   = valid1 & (~valid0 |  ptr);
  assign gnt_id = gnt1;

endmodule : rr_arb2
`default_nettype wire

// File: rtl/div_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : div_arbiter
// Description : Shares one iterative divider between two requesters (0 = EX
//               stage, 1 = microcode/trap sequencer). Round-robin accept,
//               registered operands held at the divider, restart-by-reset
//               sequencing, watchdog timeout, tagged shared response channel.
// Ports       : clk, rst                 - clock, synchronous active-high reset
//               reqN_*                   - request channels (valid/ready)
//               resp_*                   - shared response channel
//               div_a/b/signctl/rem/rst  - registered divider controls
//               div_dout, div_drdy       - divider result
// Config      : DIV_ZERO_BYPASS_EN - when defined, b==0 requests are answered
//               directly (quotient all ones, remainder = a) without the divider.
// Revision    : 1.0 - initial release
// ============================================================================
module div_arbiter
  import cpu_div_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req0_signctl,
  input  logic              req0_rem,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic              req1_signctl,
  input  logic              req1_rem,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [ID_W-1:0]   resp_id,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  output logic [DATA_W-1:0] div_a,
  output logic [DATA_W-1:0] div_b,
  output logic              div_signctl,
  output logic              div_rem,
  output logic              div_rst,
  input  logic [DATA_W-1:0] div_dout,
  input  logic              div_drdy
);

  localparam logic [CNT_W-1:0] c_timeout_last = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t            r_state;
  logic              r_ptr;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_resp_valid;
  logic [ID_W-1:0]   r_resp_id;
  logic [DATA_W-1:0] r_resp_data;
  logic              r_resp_err;
  logic [DATA_W-1:0] r_div_a;
  logic [DATA_W-1:0] r_div_b;
  logic              r_div_signctl;
  logic              r_div_rem;
  logic              r_div_rst;

  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_gnt_id;
  logic              w_idle;
  logic              w_accept;
  logic [DATA_W-1:0] w_sel_a;
  logic [DATA_W-1:0] w_sel_b;
  logic              w_sel_signctl;
  logic              w_sel_rem;

  rr_arb2 u_rr_arb2 (
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .ptr    (r_ptr),
    .gnt0   (w_gnt0),
    .gnt1   (w_gnt1),
    .gnt_id (w_gnt_id)
  );

  // Grants are only offered from IDLE; the RESP->IDLE handshake cycle is
  // still RESP, so no grant can overlap it. Reset masks any grant so a
  // requester never sees an acceptance that the reset edge discards.
  assign w_idle     = (r_state == S_IDLE) & ~rst;
  assign req0_ready = w_idle & w_gnt0;
  assign req1_ready = w_idle & w_gnt1;
  assign w_accept   = req0_ready | req1_ready;

  assign w_sel_a       = w_gnt_id ? req1_a       : req0_a;
  assign w_sel_b       = w_gnt_id ? req1_b       : req0_b;
  assign w_sel_signctl = w_gnt_id ? req1_signctl : req0_signctl;
  assign w_sel_rem     = w_gnt_id ? req1_rem     : req0_rem;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_ptr         <= 1'b0;
      r_cnt         <= '0;
      r_resp_valid  <= 1'b0;
      r_resp_id     <= '0;
      r_resp_data   <= '0;
      r_resp_err    <= 1'b0;
      r_div_a       <= '0;
      r_div_b       <= '0;
      r_div_signctl <= 1'b0;
      r_div_rem     <= 1'b0;
      r_div_rst     <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_div_a       <= w_sel_a;
            r_div_b       <= w_sel_b;
            r_div_signctl <= w_sel_signctl;
            r_div_rem     <= w_sel_rem;
            r_resp_id     <= ID_W'(w_gnt_id);
`ifdef DIV_ZERO_BYPASS_EN
            if (w_sel_b == '0) begin
              // Answer immediately; the divider stays in reset.
              r_resp_data  <= w_sel_rem ? w_sel_a : DIV_ZERO_QUOT[DATA_W-1:0];
              r_resp_err   <= 1'b0;
              r_resp_valid <= 1'b1;
              r_state      <= S_RESP;
            end else begin
              r_state <= S_START;
            end
`else
            r_state <= S_START;
`endif
          end
        end

        S_START: begin
          // Operands have been stable for a full cycle under reset; release
          // the divider on entry to BUSY.
          r_cnt     <= '0;
          r_div_rst <= 1'b0;
          r_state   <= S_BUSY;
        end

        S_BUSY: begin
          r_cnt <= r_cnt + 1'b1;
          if (div_drdy) begin
            r_resp_data  <= div_dout;
            r_resp_err   <= 1'b0;
            r_resp_valid <= 1'b1;
            r_div_rst    <= 1'b1;
            r_state      <= S_RESP;
          end else if (r_cnt == c_timeout_last) begin
            r_resp_data  <= '0;
            r_resp_err   <= 1'b1;
            r_resp_valid <= 1'b1;
            r_div_rst    <= 1'b1;
            r_state      <= S_RESP;
          end
        end

        S_RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            // The requester just served loses priority to the other one.
            r_ptr        <= ~r_resp_id[0];
            r_state      <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign resp_valid  = r_resp_valid;
  assign resp_id     = r_resp_id;
  assign resp_data   = r_resp_data;
  assign resp_err    = r_resp_err;
  assign div_a       = r_div_a;
  assign div_b       = r_div_b;
  assign div_signctl = r_div_signctl;
  assign div_rem     = r_div_rem;
  assign div_rst     = r_div_rst;

endmodule : div_arbiter
`default_nettype wire

// File: tb/tb_div_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_arbiter
// Description : Directed self-checking bench for div_arbiter with a small
//               behavioural divider (fixed latency, optional hang).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_arbiter;

  localparam int DW  = 32;
  localparam int LAT = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req0_ready, req0_signctl, req0_rem;
  logic [DW-1:0] req0_a, req0_b;
  logic          req1_valid, req1_ready, req1_signctl, req1_rem;
  logic [DW-1:0] req1_a, req1_b;
  logic          resp_valid, resp_ready, resp_err;
  logic [0:0]    resp_id;
  logic [DW-1:0] resp_data;
  logic [DW-1:0] div_a, div_b, div_dout;
  logic          div_signctl, div_rem, div_rst, div_drdy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int low_cnt = 0;
  bit m_hang = 1'b0;
  int m_cnt  = 0;

  always #5 clk = ~clk;

  div_arbiter #(.DATA_W(DW), .TIMEOUT_CYCLES(64), .CNT_W(7)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_signctl(req0_signctl), .req0_rem(req0_rem),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_signctl(req1_signctl), .req1_rem(req1_rem),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_data(resp_data), .resp_err(resp_err),
    .div_a(div_a), .div_b(div_b), .div_signctl(div_signctl), .div_rem(div_rem),
    .div_rst(div_rst), .div_dout(div_dout), .div_drdy(div_drdy)
  );

  function automatic logic [DW-1:0] mdiv(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                         input logic s, input logic r);
    logic signed [DW-1:0] sa, sb;
    sa = a; sb = b;
    if (s) begin
      if (r) return sa % sb;
      return sa / sb;
    end
    if (r) return a % b;
    return a / b;
  endfunction

  // Behavioural divider: restarts while div_rst is high, answers LAT cycles later.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (div_rst === 1'b0) low_cnt <= low_cnt + 1;
    if (div_rst !== 1'b0) begin
      m_cnt    <= 0;
      div_drdy <= 1'b0;
      div_dout <= '0;
    end else if (!m_hang) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == LAT - 1) begin
        div_drdy <= 1'b1;
        div_dout <= mdiv(div_a, div_b, div_signctl, div_rem);
      end
    end
  end

  task automatic send(input bit p, input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic sc, input logic rm, output int acc, output bit ok);
    @(negedge clk);
    if (!p) begin req0_valid = 1; req0_a = a; req0_b = b; req0_signctl = sc; req0_rem = rm; end
    else    begin req1_valid = 1; req1_a = a; req1_b = b; req1_signctl = sc; req1_rem = rm; end
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      #1;
      if ((!p && req0_ready) || (p && req1_ready)) begin ok = 1; break; end
      @(negedge clk);
    end
    acc = cyc;
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
  endtask

  task automatic get_resp(output bit ok);
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (resp_valid) begin ok = 1; break; end
    end
  endtask

  task automatic consume();
    resp_ready = 1;
    @(posedge clk); #1;
    resp_ready = 0;
  endtask

  task automatic test_reset();
    rst = 1; req0_valid = 0; req1_valid = 0; resp_ready = 0;
    req0_a = 0; req0_b = 0; req0_signctl = 0; req0_rem = 0;
    req1_a = 0; req1_b = 0; req1_signctl = 0; req1_rem = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if ({resp_valid, resp_id, resp_err, div_signctl, div_rem, div_rst} !== 6'b000001) begin bad++;
      $display("FAIL reset_ctl got=%b want=000001", {resp_valid, resp_id, resp_err, div_signctl, div_rem, div_rst}); end
    total++; if ({resp_data, div_a, div_b} !== '0) begin bad++;
      $display("FAIL reset_data got=%h/%h/%h want=0", resp_data, div_a, div_b); end
    rst = 0;
  endtask

  task automatic test_unsigned();
    int acc; bit ok;
    send(0, 100, 7, 0, 0, acc, ok);
    total++; if (!ok) begin bad++; $display("FAIL u_accept got=timeout want=ready"); end
    @(negedge clk);
    total++; if ({div_a, div_b, div_rst} !== {32'd100, 32'd7, 1'b1}) begin bad++;
      $display("FAIL start_ops got=%0d/%0d/%b want=100/7/1", div_a, div_b, div_rst); end
    get_resp(ok);
    total++; if (!ok || {resp_id, resp_err, resp_data} !== {1'b0, 1'b0, 32'd14}) begin bad++;
      $display("FAIL u_quot got=%b/%b/%0d want=0/0/14", resp_id, resp_err, resp_data); end
    consume();
    send(0, 100, 7, 0, 1, acc, ok);
    get_resp(ok);
    total++; if (!ok || {resp_id, resp_err, resp_data} !== {1'b0, 1'b0, 32'd2}) begin bad++;
      $display("FAIL u_rem got=%b/%b/%0d want=0/0/2", resp_id, resp_err, resp_data); end
    consume();
  endtask

  task automatic test_signed();
    int acc; bit ok;
    send(1, 32'hFFFFFFF9, 2, 1, 0, acc, ok);
    get_resp(ok);
    total++; if (!ok || {resp_id, resp_err, resp_data} !== {1'b1, 1'b0, 32'hFFFFFFFD}) begin bad++;
      $display("FAIL s_quot got=%b/%b/%h want=1/0/fffffffd", resp_id, resp_err, resp_data); end
    consume();
    send(1, 32'hFFFFFFF9, 2, 1, 1, acc, ok);
    get_resp(ok);
    total++; if (!ok || {resp_id, resp_err, resp_data} !== {1'b1, 1'b0, 32'hFFFFFFFF}) begin bad++;
      $display("FAIL s_rem got=%b/%b/%h want=1/0/ffffffff", resp_id, resp_err, resp_data); end
    consume();
  endtask

  task automatic test_round_robin();
    logic [0:0]    ids [4];
    logic [DW-1:0] dat [4];
    logic [0:0]    exp_id [4];
    logic [DW-1:0] exp_d  [4];
    int n;
    exp_id = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp_d  = '{32'd4, 32'd3, 32'd4, 32'd3};
    @(negedge clk);
    rst = 1;
    req0_valid = 1; req0_a = 20; req0_b = 5; req0_signctl = 0; req0_rem = 0;
    req1_valid = 1; req1_a = 9;  req1_b = 3; req1_signctl = 0; req1_rem = 0;
    resp_ready = 1;
    @(negedge clk);
    rst = 0;
    n = 0;
    for (int i = 0; i < 400 && n < 4; i++) begin
      @(negedge clk);
      if (resp_valid) begin ids[n] = resp_id; dat[n] = resp_data; n++; end
    end
    req0_valid = 0; req1_valid = 0;
    @(posedge clk); #1;
    resp_ready = 0;
    total++; if (n != 4) begin bad++; $display("FAIL rr_count got=%0d want=4", n); end
    for (int k = 0; k < n; k++) begin
      total++; if ({ids[k], dat[k]} !== {exp_id[k], exp_d[k]}) begin bad++;
        $display("FAIL rr_order[%0d] got=%b/%0d want=%b/%0d", k, ids[k], dat[k], exp_id[k], exp_d[k]); end
    end
  endtask

  task automatic test_backpressure();
    int acc; bit ok; bit stable;
    send(0, 100, 7, 0, 0, acc, ok);
    get_resp(ok);
    req0_valid = 1; req0_a = 20; req0_b = 5; req0_signctl = 0; req0_rem = 0;
    stable = ok;
    for (int i = 0; i < 10; i++) begin
      #1;
      if ({resp_valid, resp_id, resp_err, resp_data, req0_ready} !== {1'b1, 1'b0, 1'b0, 32'd14, 1'b0}) stable = 0;
      @(negedge clk);
    end
    total++; if (!stable) begin bad++; $display("FAIL bp_hold got=unstable want=stable"); end
    resp_ready = 1;
    #1;
    total++; if ({resp_valid, req0_ready} !== 2'b10) begin bad++;
      $display("FAIL bp_hs_nogrant got=%b want=10", {resp_valid, req0_ready}); end
    @(posedge clk); #1;
    resp_ready = 0;
    @(negedge clk); #1;
    total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL bp_next_grant got=%b want=1", req0_ready); end
    @(posedge clk); #1;
    req0_valid = 0;
    get_resp(ok);
    total++; if (!ok || resp_data !== 32'd4) begin bad++; $display("FAIL bp_second got=%0d want=4", resp_data); end
    consume();
  endtask

  task automatic test_timeout();
    int acc; bit ok; int seen;
    m_hang = 1;
    send(0, 50, 3, 0, 0, acc, ok);
    get_resp(ok);
    total++; if (!ok || (cyc - acc) != 66) begin bad++; $display("FAIL to_latency got=%0d want=66", cyc - acc); end
    total++; if ({resp_id, resp_err, resp_data} !== {1'b0, 1'b1, 32'd0}) begin bad++;
      $display("FAIL to_resp got=%b/%b/%h want=0/1/0", resp_id, resp_err, resp_data); end
    consume();
    send(1, 77, 5, 0, 0, acc, ok);
    repeat (10) @(negedge clk);
    #1;
    total++; if (div_rst !== 1'b0) begin bad++; $display("FAIL busy_divrst got=%b want=0", div_rst); end
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    total++; if ({div_rst, resp_valid, resp_id, div_a, div_b} !== {1'b1, 1'b0, 1'b0, 32'd0, 32'd0}) begin bad++;
      $display("FAIL midrst got=%b/%b/%b/%0d/%0d want=1/0/0/0/0", div_rst, resp_valid, resp_id, div_a, div_b); end
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (resp_valid !== 1'b0 || div_rst !== 1'b1) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL midrst_quiet got=%0d want=0", seen); end
    m_hang = 0;
  endtask

`ifdef DIV_ZERO_BYPASS_EN
  task automatic test_bypass();
    int acc; bit ok; int low0;
    low0 = low_cnt;
    send(0, 55, 0, 0, 0, acc, ok);
    get_resp(ok);
    total++; if (!ok || (cyc - acc) != 1) begin bad++; $display("FAIL byp_latency got=%0d want=1", cyc - acc); end
    total++; if ({resp_err, resp_data} !== {1'b0, 32'hFFFFFFFF}) begin bad++;
      $display("FAIL byp_quot got=%b/%h want=0/ffffffff", resp_err, resp_data); end
    consume();
    send(0, 55, 0, 0, 1, acc, ok);
    get_resp(ok);
    total++; if (!ok || {resp_err, resp_data} !== {1'b0, 32'd55}) begin bad++;
      $display("FAIL byp_rem got=%b/%0d want=0/55", resp_err, resp_data); end
    consume();
    total++; if (low_cnt != low0) begin bad++; $display("FAIL byp_divrst got=%0d want=%0d", low_cnt, low0); end
  endtask
`endif

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_round_robin();
    test_backpressure();
    test_timeout();
`ifdef DIV_ZERO_BYPASS_EN
    test_bypass();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_div_arbiter
`default_nettype wire

// File: doc/div_arbiter.md
Name: div_arbiter

Overview:
- Shares the single iterative divider (`div`) between two requesters: port 0 is the integer pipeline EX stage, port 1 is the microcode/trap sequencer.
- Arbitrates round-robin, latches operands and holds them stable at the divider.
- Sequences the divider's restart-by-reset protocol, waits for `drdy`, then returns the result on one shared response channel tagged with the requester id.
- A watchdog converts a hung divide into an error response.

Parameters:
- DATA_W, 32, operand/result width; must match `div`.
- TIMEOUT_CYCLES, 64, cycles in BUSY without `div_drdy` before an error response; minimum 2.
- CNT_W, 7, watchdog counter width; must satisfy 2**CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- req0_valid / req1_valid  in  1  request pending.
- req0_ready / req1_ready  out  1  request accepted this cycle (combinational from state and arbitration).
- req0_a / req1_a  in  DATA_W  dividend.
- req0_b / req1_b  in  DATA_W  divisor.
- req0_signctl / req1_signctl  in  1  1 = signed divide.
- req0_rem / req1_rem  in  1  1 = return remainder, 0 = quotient.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer takes response.
- resp_id  out  1  requester that owns the response.
- resp_data  out  DATA_W  quotient or remainder.
- resp_err  out  1  watchdog timeout; resp_data = 0.
- div_a, div_b  out  DATA_W  to divider a/b; registered.
- div_signctl, div_rem  out  1  to divider signctl/remainder_out; registered.
- div_rst  out  1  to divider rst; registered.
- div_dout  in  DATA_W  divider result.
- div_drdy  in  1  divider done.

Behaviour:
- Reset (rst=1 at an edge):
  - State goes to IDLE; priority pointer goes to 0.
  - resp_valid, resp_id, resp_data, resp_err, div_a, div_b, div_signctl and div_rem all go to 0.
  - div_rst goes to 1.
  - Reset mid-operation abandons the divide with no response; the divider is held reset.
- div_rst is 1 in IDLE, START and RESP; it is 0 only in BUSY.
- IDLE:
  - If any reqN_valid, the winner's reqN_ready=1 the same cycle.
  - Winner selection: when both are valid, the requester the priority pointer names wins; when one is valid, it wins.
  - At the edge: latch operands into div_a, div_b, div_signctl and div_rem; latch resp_id; go to START.
  - reqN_ready is 0 in every other state.
- START: one cycle; operands are stable with div_rst=1. Go to BUSY and clear the watchdog counter.
- BUSY:
  - div_rst=0; the counter increments each cycle.
  - If div_drdy=1: capture div_dout into resp_data, set resp_err=0, go to RESP.
  - Else, if counter == TIMEOUT_CYCLES-1: set resp_data=0, resp_err=1, go to RESP.
  - div_drdy takes precedence when it coincides with the timeout.
- RESP:
  - resp_valid=1; resp_id, resp_data and resp_err stay stable until resp_valid & resp_ready.
  - On that handshake: resp_valid goes to 0, the priority pointer goes to the complement of resp_id, state goes to IDLE.
  - No new grant is issued in the handshake cycle.
- Latency: accept -> resp_valid = 2 + divider cycles (START, BUSY entry, divider). Throughput is one op in flight.
- Requesters hold valid and operands stable until ready; a valid dropped before ready is legal and ignored.
- State encoding: IDLE=2'd0, START=2'd1, BUSY=2'd2, RESP=2'd3.

Optional Feature:
- DIV_ZERO_BYPASS_EN defined:
  - In IDLE, an accepted request with b==0 goes straight to RESP next cycle; the divider is not started.
  - resp_data = all ones when rem=0, = a when rem=1; resp_err=0.
- Undefined: b==0 is sent to the divider like any other divide; if it never asserts drdy, the watchdog reports the error.

Decomposition:
- Package cpu_div_pkg holds:
  - state encoding localparams;
  - DIV_ZERO_QUOT = {DATA_W{1'b1}};
  - the ID_W=1 constant.
- One sub-module, rr_arb2: 2-way round-robin grant.
  - Inputs: valid0, valid1, ptr.
  - Outputs: gnt0, gnt1, gnt_id.
  - Purely combinational; the pointer register lives in div_arbiter.

Test Plan:
- req0 a=100 b=7 signctl=0 rem=0, then rem=1 -> resp_id=0, resp_data=14, then 2; resp_err=0.
- req1 a=32'hFFFFFFF9 (-7) b=2 signctl=1 rem=0 -> resp_data=32'hFFFFFFFD (-3, truncating); rem=1 -> 32'hFFFFFFFF.
- Both valid from reset-release, a0=20 b0=5, a1=9 b1=3 -> req0 served first (data 4, id 0), then req1 (data 3, id 1). Repeat both valid -> req1 is now not starved: order alternates.
- Hold resp_ready=0 for 10 cycles with req0 valid -> resp fields stable, req0_ready stays 0; release -> next grant occurs no earlier than the cycle after the handshake.
- div_drdy tied 0, TIMEOUT_CYCLES=64 -> resp_valid with resp_err=1, resp_data=0 exactly 2+64 cycles after accept. Assert rst mid-BUSY -> no response; div_rst=1 and outputs return to reset values.
- With DIV_ZERO_BYPASS_EN: a=55 b=0 rem=0 -> 32'hFFFFFFFF one cycle after accept, div_rst never low; rem=1 -> 55.
